pipeline_mem: RTL and testbench

PIPELINE_MEM -- requirements
Module: pipeline_mem

---
 rtl/pipeline_mem.sv | 140 ++++++++++++++
 tb/tb_pipeline_mem.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_mem.sv
// Memory stage of an in-order pipeline: runs non-memory ops through to writeback,
// issues one load/store request per instruction and formats load data.
module pipeline_mem #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  ready,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] ex_res,
  input  logic [DATA_WIDTH-1:0] r2_val_mem,
  input  logic [4:0]            mem_dst_reg,
  input  logic [31:0]           mem_opcode,
  input  logic                  is_mem_load,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic                  mem_req_we,
  output logic [63:0]           mem_req_wdata,
  output logic [7:0]            mem_req_strb,
  input  logic                  mem_resp_valid,
  input  logic [63:0]           mem_resp_data,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic                  wb_we,
  output logic [4:0]            wb_dst_reg,
  output logic [DATA_WIDTH-1:0] wb_data
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] exRes_q;
  logic [DATA_WIDTH-1:0] r2_q;
  logic [4:0]            dst_q;
  logic                  isMem_q;
  logic                  isLoad_q;
  logic [1:0]            size_q;
  logic                  zext_q;
  logic [63:0]           resp_q;

  logic                  accept;
  logic [2:0]            offset;
  logic [5:0]            shiftBits;
  logic [7:0]            sizeMask;
  logic [63:0]           shifted;
  logic [63:0]           loadData;
  logic [63:0]           wbDataInt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      exRes_q  <= '0;
      r2_q     <= '0;
      dst_q    <= '0;
      isMem_q  <= 1'b0;
      isLoad_q <= 1'b0;
      size_q   <= '0;
      zext_q   <= 1'b0;
      resp_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        exRes_q  <= ex_res;
        r2_q     <= r2_val_mem;
        dst_q    <= mem_dst_reg;
        isMem_q  <= |mem_opcode;
        isLoad_q <= is_mem_load;
        size_q   <= mem_opcode[1:0];
        zext_q   <= mem_opcode[2];
      end
      if (state_q == WAIT && mem_resp_valid)
        resp_q <= mem_resp_data;
    end
  end

  // A retiring instruction in OUT frees the stage in the same cycle, so a new one can follow without a bubble.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: ready = 1'b1;
      REQ:  if (mem_req_ready) state_d = isLoad_q ? WAIT : OUT;
      WAIT: if (mem_resp_valid) state_d = OUT;
      OUT: begin
        ready = wb_ready;
        if (wb_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) ready = 1'b0;
    if (ready && in_valid) begin
      accept  = 1'b1;
      state_d = (|mem_opcode) ? REQ : OUT;
    end
  end

  always_comb begin
    offset    = exRes_q[2:0];
    shiftBits = {offset, 3'b000};
    shifted   = resp_q >> shiftBits;
    sizeMask  = 8'h01;
    loadData  = '0;
    case (size_q)
      2'd0: begin
        sizeMask = 8'h01;
        loadData = zext_q ? {56'b0, shifted[7:0]} : {{56{shifted[7]}}, shifted[7:0]};
      end
      2'd1: begin
        sizeMask = 8'h03;
        loadData = zext_q ? {48'b0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      end
      2'd2: begin
        sizeMask = 8'h0F;
        loadData = zext_q ? {32'b0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      end
      default: begin
        sizeMask = 8'hFF;
        loadData = shifted;
      end
    endcase
    wbDataInt = (isMem_q && isLoad_q) ? loadData : exRes_q;
  end

  // Every output is forced low while reset is held so nothing leaks from a half-finished op.
  always_comb begin
    mem_req_valid = !reset && (state_q == REQ);
    mem_req_addr  = reset ? '0 : ADDR_WIDTH'(exRes_q);
    mem_req_we    = !reset && isMem_q && !isLoad_q;
    mem_req_wdata = reset ? '0 : (r2_q << shiftBits);
    mem_req_strb  = reset ? '0 : (sizeMask << offset);
    wb_valid      = !reset && (state_q == OUT);
    wb_we         = !reset && (state_q == OUT) && (!isMem_q || isLoad_q) && (dst_q != 5'd0);
    wb_dst_reg    = reset ? '0 : dst_q;
    wb_data       = reset ? '0 : wbDataInt;
  end

endmodule

// File: tb/tb_pipeline_mem.sv
// Bench for pipeline_mem: transaction-level model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_pipeline_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic        in_valid;
  logic [63:0] ex_res;
  logic [63:0] r2_val_mem;
  logic [4:0]  mem_dst_reg;
  logic [31:0] mem_opcode;
  logic        is_mem_load;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_req_we;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_strb;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_we;
  logic [4:0]  wb_dst_reg;
  logic [63:0] wb_data;

  pipeline_mem #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
    .clk(clk), .reset(reset), .ready(ready),
    .in_valid(in_valid), .ex_res(ex_res), .r2_val_mem(r2_val_mem),
    .mem_dst_reg(mem_dst_reg), .mem_opcode(mem_opcode), .is_mem_load(is_mem_load),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata), .mem_req_strb(mem_req_strb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we),
    .wb_dst_reg(wb_dst_reg), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;
  bit started    = 1'b0;

  // Model: one in-flight instruction plus which memory phases it has completed.
  typedef struct {
    logic [63:0] exres;
    logic [63:0] r2;
    logic [4:0]  dst;
    logic        isMem;
    logic        isLoad;
    logic [1:0]  size;
    logic        zext;
    logic [63:0] resp;
  } txn_t;

  txn_t cur;
  bit   pending  = 1'b0;
  bit   reqDone  = 1'b0;
  bit   respDone = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic bit inOut();
    return pending && (!cur.isMem || (reqDone && (!cur.isLoad || respDone)));
  endfunction

  function automatic bit inReq();
    return pending && cur.isMem && !reqDone;
  endfunction

  function automatic bit inWait();
    return pending && cur.isMem && cur.isLoad && reqDone && !respDone;
  endfunction

  function automatic bit expReady();
    return !reset && (!pending || (inOut() && wb_ready));
  endfunction

  function automatic logic [63:0] expLoad(input txn_t t);
    int nbytes = 1 << t.size;
    int bits   = nbytes * 8;
    logic [63:0] v = t.resp >> (t.exres[2:0] * 8);
    logic [63:0] mask;
    if (bits < 64) begin
      mask = (64'h1 << bits) - 64'h1;
      v = v & mask;
      if (!t.zext && v[bits-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic logic [7:0] expStrb(input txn_t t);
    logic [7:0] s = '0;
    int off = int'(t.exres[2:0]);
    for (int b = off; b < off + (1 << t.size); b++)
      if (b < 8) s[b] = 1'b1;
    return s;
  endfunction

  initial begin
    bit acc;
    forever begin
      @(posedge clk);
      if (reset) pending = 1'b0;
      else begin
        acc = in_valid && expReady();
        if (acc) begin
          cur.exres  = ex_res;
          cur.r2     = r2_val_mem;
          cur.dst    = mem_dst_reg;
          cur.isMem  = (mem_opcode != 32'd0);
          cur.isLoad = is_mem_load;
          cur.size   = mem_opcode[1:0];
          cur.zext   = mem_opcode[2];
          cur.resp   = '0;
          pending = 1'b1; reqDone = 1'b0; respDone = 1'b0;
        end else if (inOut() && wb_ready) pending = 1'b0;
        else if (inReq() && mem_req_ready) reqDone = 1'b1;
        else if (inWait() && mem_resp_valid) begin
          respDone = 1'b1;
          cur.resp = mem_resp_data;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        checkOutput("ready", 64'(ready), 64'(expReady()));
        checkOutput("mem_req_valid", 64'(mem_req_valid), 64'(!reset && inReq()));
        checkOutput("wb_valid", 64'(wb_valid), 64'(!reset && inOut()));
        if (reset) begin
          checkOutput("rst_wb_data", wb_data, 64'h0);
          checkOutput("rst_req_addr", mem_req_addr, 64'h0);
          checkOutput("rst_wb_we", 64'(wb_we), 64'h0);
        end else if (inReq()) begin
          checkOutput("req_addr", mem_req_addr, cur.exres);
          checkOutput("req_we", 64'(mem_req_we), 64'(!cur.isLoad));
          if (!cur.isLoad) begin
            checkOutput("req_wdata", mem_req_wdata, cur.r2 << (cur.exres[2:0] * 8));
            checkOutput("req_strb", 64'(mem_req_strb), 64'(expStrb(cur)));
          end
        end else if (inOut()) begin
          checkOutput("wb_we", 64'(wb_we), 64'((!cur.isMem || cur.isLoad) && cur.dst != 5'd0));
          checkOutput("wb_dst", 64'(wb_dst_reg), 64'(cur.dst));
          if (!cur.isMem) checkOutput("wb_data_alu", wb_data, cur.exres);
          else if (cur.isLoad) checkOutput("wb_data_load", wb_data, expLoad(cur));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction and holds it until the cycle it is accepted.
  task automatic applyStimulus(input logic [31:0] op, input logic ld, input logic [63:0] addr,
                               input logic [63:0] r2, input logic [4:0] dst);
    bit accepted = 1'b0;
    mem_opcode = op; is_mem_load = ld; ex_res = addr; r2_val_mem = r2; mem_dst_reg = dst;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ready) begin
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) checkOutput("accept_timeout", 64'h0, 64'h1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic runLoad(input logic [31:0] op, input logic [63:0] addr,
                         input logic [63:0] resp, input logic [63:0] exp);
    mem_req_ready = 1'b1;
    applyStimulus(op, 1'b1, addr, 64'h0, 5'd7);
    @(negedge clk);
    checkOutput("ld_req_valid", 64'(mem_req_valid), 64'h1);
    checkOutput("ld_req_we", 64'(mem_req_we), 64'h0);
    tick();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data = resp;
    @(negedge clk);
    checkOutput("ld_wait_wb_valid", 64'(wb_valid), 64'h0);
    tick();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    checkOutput("ld_wb_valid", 64'(wb_valid), 64'h1);
    checkOutput("ld_wb_data", wb_data, exp);
    tick();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; ex_res = '0; r2_val_mem = '0; mem_dst_reg = '0;
    mem_opcode = '0; is_mem_load = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    mem_resp_data = '0; wb_ready = 1'b1;
    tick(); tick();
    started = 1'b1;
    @(negedge clk);
    checkOutput("reset_wb_valid", 64'(wb_valid), 64'h0);
    checkOutput("reset_req_valid", 64'(mem_req_valid), 64'h0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_ready", 64'(ready), 64'h1);
    tick();

    $display("[TB] non-memory op");
    applyStimulus(32'h0, 1'b0, 64'h1234, 64'h0, 5'd5);
    @(negedge clk);
    checkOutput("alu_wb_valid", 64'(wb_valid), 64'h1);
    checkOutput("alu_wb_data", wb_data, 64'h1234);
    checkOutput("alu_wb_we", 64'(wb_we), 64'h1);
    tick();

    $display("[TB] loads");
    runLoad(32'h10, 64'h1003, 64'h00000000_80000000, 64'hFFFFFFFF_FFFFFF80);
    runLoad(32'h5, 64'h2006, 64'hBEEF0000_00000000, 64'h00000000_0000BEEF);

    $display("[TB] word store with stalled request");
    mem_req_ready = 1'b0;
    applyStimulus(32'h2, 1'b0, 64'h10, 64'hDEADBEEF, 5'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("st_req_valid", 64'(mem_req_valid), 64'h1);
      checkOutput("st_req_addr", mem_req_addr, 64'h10);
      checkOutput("st_strb", 64'(mem_req_strb), 64'h0F);
      checkOutput("st_wdata_lo", 64'(mem_req_wdata[31:0]), 64'hDEADBEEF);
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    @(negedge clk);
    checkOutput("st_wb_valid", 64'(wb_valid), 64'h1);
    checkOutput("st_wb_we", 64'(wb_we), 64'h0);
    tick();

    $display("[TB] writeback backpressure");
    wb_ready = 1'b0;
    applyStimulus(32'h0, 1'b0, 64'hAAAA, 64'h0, 5'd9);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("bp_ready", 64'(ready), 64'h0);
      checkOutput("bp_wb_data", wb_data, 64'hAAAA);
      checkOutput("bp_wb_dst", 64'(wb_dst_reg), 64'd9);
      tick();
    end
    wb_ready = 1'b1;
    in_valid = 1'b1; mem_opcode = 32'h0; ex_res = 64'h5555; mem_dst_reg = 5'd10;
    @(negedge clk);
    checkOutput("bp_release_ready", 64'(ready), 64'h1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("b2b_wb_data", wb_data, 64'h5555);
    checkOutput("b2b_wb_dst", 64'(wb_dst_reg), 64'd10);
    tick();

    $display("[TB] reset during WAIT");
    mem_req_ready = 1'b1;
    applyStimulus(32'h3, 1'b1, 64'h40, 64'h0, 5'd4);
    tick();
    mem_req_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data = 64'h0123_4567_89AB_CDEF;
    tick();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    checkOutput("late_resp_wb_valid", 64'(wb_valid), 64'h0);
    checkOutput("late_resp_ready", 64'(ready), 64'h1);
    tick();

    $display("[TB] randomized traffic");
    for (int c = 0; c < 600; c++) begin
      int kind = $urandom_range(0, 2);
      reset         = ($urandom_range(0, 99) == 0);
      in_valid      = $urandom_range(0, 1);
      ex_res        = {$urandom, $urandom};
      r2_val_mem    = {$urandom, $urandom};
      mem_dst_reg   = 5'($urandom_range(0, 31));
      is_mem_load   = (kind == 1);
      mem_opcode    = (kind == 0) ? 32'h0 : (32'($urandom_range(0, 7)) | 32'h100);
      mem_req_ready = $urandom_range(0, 1);
      mem_resp_valid = $urandom_range(0, 1);
      mem_resp_data = {$urandom, $urandom};
      wb_ready      = ($urandom_range(0, 3) != 0);
      tick();
    end
    reset = 1'b0; in_valid = 1'b0; mem_resp_valid = 1'b0;
    tick(); tick();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
